// File: rtl/seq_div_16.sv
// Sequential restoring unsigned divider: one quotient bit per clock with a
// start/busy/done handshake; divide-by-zero short-circuits straight to DONE.
//
// state | meaning
// IDLE  | waiting for start; first restoring step happens on the accepting edge
// CALC  | one restoring step per edge until all WIDTH quotient bits are formed
// DONE  | results valid, done pulses for one cycle, then back to IDLE
module seq_div_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q_work;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] d_work;

    logic [WIDTH-1:0] op_q;
    logic [WIDTH-1:0] op_r;
    logic [WIDTH-1:0] op_d;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] nxt_q;
    logic [WIDTH-1:0] nxt_r;

    // In IDLE the step operates on the incoming operands so the accepting
    // edge already produces quotient bit WIDTH-1.
    always_comb begin
        op_q = q_work;
        op_r = r_work;
        op_d = d_work;
        if (state == IDLE) begin
            op_q = dividend;
            op_r = '0;
            op_d = divisor;
        end
        sh   = {op_r, op_q[WIDTH-1]};
        diff = sh - {1'b0, op_d};
        // A restored remainder is always below the divisor, so WIDTH bits hold it.
        if (!diff[WIDTH]) begin
            nxt_r = diff[WIDTH-1:0];
            nxt_q = {op_q[WIDTH-2:0], 1'b1};
        end else begin
            nxt_r = sh[WIDTH-1:0];
            nxt_q = {op_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            q_work      <= '0;
            r_work      <= '0;
            d_work      <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            q_work <= nxt_q;
                            r_work <= nxt_r;
                            d_work <= divisor;
                            count  <= CW'(1);
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    q_work <= nxt_q;
                    r_work <= nxt_r;
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        quotient    <= nxt_q;
                        remainder   <= nxt_r;
                        div_by_zero <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_div_16.sv
// Testbench for seq_div_16: directed handshake/corner scenarios plus random
// operands checked against plain integer division.
module tb_seq_div_16;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    seq_div_16 #(.WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    // Leaves the caller at the negedge just after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cyc, output bit timeout);
        lat = 0; busy_cyc = 0; timeout = 0;
        forever begin
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) break;
            if (lat >= 40) begin timeout = 1; break; end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; dividend = 16'hA5A5; divisor = 16'h0003;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%h r=%h, need all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b need 0", busy); end
    endtask

    task automatic test_basic;
        int lat, bc, dc; bit to;
        issue(16'd100, 16'd7);
        dc = done_cnt;
        wait_done(lat, bc, to);
        total++;
        if (to || lat != 15) begin bad++; $display("FAIL basic_latency: got %0d timeout=%0b need 15", lat, to); end
        total++;
        if (bc != 16) begin bad++; $display("FAIL basic_busy_cycles: got %0d need 16", bc); end
        total++;
        if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0) begin
            bad++; $display("FAIL basic_result: got q=%0d r=%0d dbz=%b need 14 2 0", quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== 16'd14 || done_cnt != dc + 1) begin
            bad++; $display("FAIL basic_after: done=%b busy=%b q=%0d pulses=%0d need 0 0 14 1",
                            done, busy, quotient, done_cnt - dc);
        end
    endtask

    task automatic test_corners;
        logic [15:0] na [3] = '{16'hFFFF, 16'h0003, 16'hFFFF};
        logic [15:0] da [3] = '{16'h0001, 16'h000A, 16'hFFFF};
        int lat, bc; bit to;
        for (int i = 0; i < 3; i++) begin
            issue(na[i], da[i]);
            wait_done(lat, bc, to);
            total++;
            if (to || lat != 15 || quotient !== na[i] / da[i] || remainder !== na[i] % da[i]) begin
                bad++;
                $display("FAIL corner_%0d: %h/%h got q=%h r=%h lat=%0d need q=%h r=%h lat=15",
                         i, na[i], da[i], quotient, remainder, lat, na[i] / da[i], na[i] % da[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        int lat, bc; bit to;
        issue(16'h1234, 16'h0000);
        wait_done(lat, bc, to);
        total++;
        if (to || lat != 0) begin bad++; $display("FAIL dbz_latency: got %0d need 0", lat); end
        total++;
        if (quotient !== 16'hFFFF || remainder !== 16'h1234 || div_by_zero !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL dbz_result: got q=%h r=%h dbz=%b busy=%b need ffff 1234 1 1",
                            quotient, remainder, div_by_zero, busy);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b1) begin
            bad++; $display("FAIL dbz_after: busy=%b done=%b dbz=%b need 0 0 1", busy, done, div_by_zero);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc, dc; bit to;
        issue(16'd100, 16'd7);
        dc = done_cnt;
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 16'd9; divisor = 16'd2;
        @(negedge clk);
        start = 1'b0; dividend = 16'd0; divisor = 16'd0;
        wait_done(lat, bc, to);
        total++;
        if (to || lat != 10 || quotient !== 16'd14 || remainder !== 16'd2) begin
            bad++; $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d need 14 2 10", quotient, remainder, lat);
        end
        start = 1'b1; dividend = 16'd9; divisor = 16'd2;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL b2b_idle: busy=%b done=%b need 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: busy=%b need 1", busy); end
        wait_done(lat, bc, to);
        total++;
        if (to || lat != 15 || quotient !== 16'd4 || remainder !== 16'd1 || done_cnt != dc + 1) begin
            bad++; $display("FAIL b2b_result: got q=%0d r=%0d lat=%0d pulses=%0d need 4 1 15 1",
                            quotient, remainder, lat, done_cnt - dc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, bc, dc; bit to;
        issue(16'd100, 16'd7);
        repeat (8) @(negedge clk);
        dc = done_cnt;
        reset = 1'b0;
        #1;
        total++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
            bad++; $display("FAIL reset_mid: got busy=%b done=%b dbz=%b q=%h r=%h need all 0",
                            busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (done_cnt != dc || busy !== 1'b0) begin
            bad++; $display("FAIL reset_no_done: pulses=%0d busy=%b need 0 0", done_cnt - dc, busy);
        end
        issue(16'd50, 16'd5);
        wait_done(lat, bc, to);
        total++;
        if (to || lat != 15 || quotient !== 16'd10 || remainder !== 16'd0) begin
            bad++; $display("FAIL reset_recover: got q=%0d r=%0d lat=%0d need 10 0 15", quotient, remainder, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [15:0] a, b, eq, er;
        logic [33:0] recon;
        int lat, bc, dc; bit to;
        for (int i = 0; i < 1500; i++) begin
            a = 16'($urandom);
            b = 16'($urandom_range(1, 65535));
            if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 15));
            if ($urandom_range(0, 15) == 0) a = 16'd0;
            eq = a / b;
            er = a % b;
            dc = done_cnt;
            issue(a, b);
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
            wait_done(lat, bc, to);
            recon = 34'(quotient) * 34'(b) + 34'(remainder);
            total++;
            if (to || lat != 15 || quotient !== eq || remainder !== er || div_by_zero !== 1'b0 ||
                recon != 34'(a) || remainder >= b) begin
                bad++;
                $display("FAIL random_%0d: %h/%h got q=%h r=%h dbz=%b lat=%0d need q=%h r=%h dbz=0 lat=15",
                         i, a, b, quotient, remainder, div_by_zero, lat, eq, er);
            end
            @(negedge clk);
            total++;
            if (done_cnt != dc + 1) begin
                bad++; $display("FAIL random_pulses_%0d: got %0d need 1", i, done_cnt - dc);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_corners;
        test_div_zero;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
